// File: rtl/video_pkg.sv
// Shared definitions for the video pattern scheduler: pattern encodings,
// scheduler FSM states and the pattern-step helper.
package video_pkg;

  localparam logic [1:0] PAT_CHECKER = 2'd0;
  localparam logic [1:0] PAT_BARS    = 2'd1;
  localparam logic [1:0] PAT_HRAMP   = 2'd2;
  localparam logic [1:0] PAT_VRAMP   = 2'd3;

  typedef enum logic [1:0] {
    LOCK = 2'd0,
    IDLE = 2'd1,
    PEND = 2'd2
  } sched_state_t;

  // Patterns wrap 3 -> 0.
  function automatic logic [1:0] next_pat(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/frame_edge_det.sv
// Detects the vsync 1->0 edge (frame boundary) and registers it as frame_start_o.
module frame_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync_i,
  output logic fall_o,
  output logic frame_start_o
);

  logic vsync_q, vsync_d;
  logic frame_start_q, frame_start_d;

  // vsync_q resets low so a low vsync right after reset is not a boundary.
  assign fall_o = vsync_q & ~vsync_i;

  always_comb begin
    vsync_d       = vsync_i;
    frame_start_d = fall_o;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start_o = frame_start_q;

endmodule

// File: rtl/video_pattern_sched.sv
// Frame-synchronous scheduler for the generator pattern select: arbitrates host,
// button and auto-cycle changes and applies the winner only at a vsync fall.
module video_pattern_sched
  import video_pkg::*;
#(
  parameter int         DWELL_W         = 8,
  parameter logic [1:0] DEFAULT_PATTERN = PAT_BARS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync_i,
  input  logic               auto_en_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               host_req_i,
  input  logic [1:0]         host_pattern_i,
  output logic               host_ack_o,
  input  logic               btn_step_i,
  output logic [1:0]         video_pattern_o,
  output logic               frame_start_o,
  output logic               pattern_chg_o,
  output logic               pending_o
);

  logic fall;

  frame_edge_det u_edge (
    .clk           (clk),
    .rst           (rst),
    .vsync_i       (vsync_i),
    .fall_o        (fall),
    .frame_start_o (frame_start_o)
  );

  sched_state_t       state_q, state_d;
  logic               host_pend_q, host_pend_d;
  logic [1:0]         host_pat_q, host_pat_d;
  logic               btn_pend_q, btn_pend_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [1:0]         pattern_q, pattern_d;
  logic               ack_q, ack_d;
  logic               chg_q, chg_d;
  logic               pending_q, pending_d;

  logic               host_acc;
  logic               pend_any;
  logic [DWELL_W:0]   cnt_inc;
  logic [DWELL_W:0]   dwell_eff;

  always_comb begin
    host_acc  = host_req_i & ~host_pend_q;
    cnt_inc   = {1'b0, dwell_cnt_q} + (DWELL_W+1)'(1);
    dwell_eff = (dwell_i == '0) ? (DWELL_W+1)'(1) : {1'b0, dwell_i};

    host_pend_d = host_pend_q | host_acc;
    host_pat_d  = host_acc ? host_pattern_i : host_pat_q;
    btn_pend_d  = btn_pend_q | btn_step_i;
    pattern_d   = pattern_q;
    dwell_cnt_d = auto_en_i ? dwell_cnt_q : '0;
    state_d     = state_q;

    // Only requests already pending before this cycle are eligible; anything
    // accepted in the fall cycle itself waits for the next boundary.
    if (fall) begin
      if (host_pend_q) begin
        pattern_d   = host_pat_q;
        host_pend_d = 1'b0;
        dwell_cnt_d = '0;
      end else if (btn_pend_q) begin
        pattern_d   = next_pat(pattern_q);
        btn_pend_d  = btn_step_i;
        dwell_cnt_d = '0;
      end else if (state_q != LOCK && auto_en_i) begin
        if (cnt_inc >= dwell_eff) begin
          pattern_d   = next_pat(pattern_q);
          dwell_cnt_d = '0;
        end else begin
          dwell_cnt_d = cnt_inc[DWELL_W-1:0];
        end
      end
    end

    pend_any = host_pend_d | btn_pend_d;

    case (state_q)
      LOCK:       if (fall) state_d = pend_any ? PEND : IDLE;
      IDLE, PEND: state_d = pend_any ? PEND : IDLE;
      default:    state_d = LOCK;
    endcase

    ack_d     = host_acc;
    chg_d     = fall & (pattern_d != pattern_q);
    pending_d = pend_any;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOCK;
      host_pend_q <= 1'b0;
      host_pat_q  <= 2'd0;
      btn_pend_q  <= 1'b0;
      dwell_cnt_q <= '0;
      pattern_q   <= DEFAULT_PATTERN;
      ack_q       <= 1'b0;
      chg_q       <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      host_pend_q <= host_pend_d;
      host_pat_q  <= host_pat_d;
      btn_pend_q  <= btn_pend_d;
      dwell_cnt_q <= dwell_cnt_d;
      pattern_q   <= pattern_d;
      ack_q       <= ack_d;
      chg_q       <= chg_d;
      pending_q   <= pending_d;
    end
  end

  assign host_ack_o      = ack_q;
  assign video_pattern_o = pattern_q;
  assign pattern_chg_o   = chg_q;
  assign pending_o       = pending_q;

endmodule

// File: tb/tb_video_pattern_sched.sv
// Directed bench for video_pattern_sched with hand-computed expectations.
module tb_video_pattern_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       auto_en;
  logic [7:0] dwell;
  logic       host_req;
  logic [1:0] host_pat;
  logic       host_ack;
  logic       btn_step;
  logic [1:0] pattern;
  logic       frame_start;
  logic       pattern_chg;
  logic       pending;

  int total = 0;
  int bad   = 0;

  video_pattern_sched #(.DWELL_W(8), .DEFAULT_PATTERN(2'd1)) dut (
    .clk             (clk),
    .rst             (rst),
    .vsync_i         (vsync),
    .auto_en_i       (auto_en),
    .dwell_i         (dwell),
    .host_req_i      (host_req),
    .host_pattern_i  (host_pat),
    .host_ack_o      (host_ack),
    .btn_step_i      (btn_step),
    .video_pattern_o (pattern),
    .frame_start_o   (frame_start),
    .pattern_chg_o   (pattern_chg),
    .pending_o       (pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; outputs read at negedge reflect the prior posedge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic frame_high(input int n);
    vsync = 1'b1;
    repeat (n) tick();
  endtask

  task automatic boundary(input logic [1:0] exp_pat, input logic exp_chg,
                          input logic exp_pend, input string tag);
    vsync = 1'b0;
    tick();
    check({tag, ".fs"},   frame_start, 1);
    check({tag, ".pat"},  pattern,     exp_pat);
    check({tag, ".chg"},  pattern_chg, exp_chg);
    check({tag, ".pend"}, pending,     exp_pend);
    tick();
    check({tag, ".fs_off"},  frame_start, 0);
    check({tag, ".chg_off"}, pattern_chg, 0);
  endtask

  task automatic host_request(input logic [1:0] p, input string tag);
    host_req = 1'b1;
    host_pat = p;
    tick();
    check({tag, ".ack"},  host_ack, 1);
    check({tag, ".pend"}, pending,  1);
    host_req = 1'b0;
    tick();
    check({tag, ".ack_off"}, host_ack, 0);
  endtask

  task automatic btn_pulse();
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; vsync = 1'b0; auto_en = 1'b0; dwell = 8'd0;
    host_req = 1'b0; host_pat = 2'd0; btn_step = 1'b0;
    repeat (3) tick();
    check("rst.pat",  pattern,     1);
    check("rst.ack",  host_ack,    0);
    check("rst.fs",   frame_start, 0);
    check("rst.chg",  pattern_chg, 0);
    check("rst.pend", pending,     0);
    rst = 1'b0;
    tick();
    check("post_rst_low.fs", frame_start, 0);

    // Idle frames, auto off: first is the LOCK boundary
    for (int i = 0; i < 3; i++) begin
      frame_high(5);
      boundary(2'd1, 1'b0, 1'b0, "idle");
    end

    // Host request for pattern 3 mid-frame
    frame_high(3);
    host_request(2'd3, "h3");
    frame_high(3);
    check("h3.hold_pat", pattern, 1);
    boundary(2'd3, 1'b1, 1'b0, "h3.b");

    // Host 0 and button in the same frame
    frame_high(2);
    host_request(2'd0, "h0");
    btn_pulse();
    btn_pulse();
    boundary(2'd0, 1'b1, 1'b1, "hb.b1");
    frame_high(4);
    boundary(2'd1, 1'b1, 1'b0, "hb.b2");

    // Host request for the current pattern: consumed without a change pulse
    frame_high(2);
    host_request(2'd1, "hsame");
    boundary(2'd1, 1'b0, 1'b0, "hsame.b");

    // Auto-cycle, dwell 2
    auto_en = 1'b1; dwell = 8'd2;
    frame_high(4);
    boundary(2'd1, 1'b0, 1'b0, "auto2.1");
    frame_high(4); boundary(2'd2, 1'b1, 1'b0, "auto2.2");
    frame_high(4); boundary(2'd2, 1'b0, 1'b0, "auto2.3");
    frame_high(4); boundary(2'd3, 1'b1, 1'b0, "auto2.4");
    frame_high(4); boundary(2'd3, 1'b0, 1'b0, "auto2.5");
    frame_high(4); boundary(2'd0, 1'b1, 1'b0, "auto2.6");
    frame_high(4); boundary(2'd0, 1'b0, 1'b0, "auto2.7");
    frame_high(4); boundary(2'd1, 1'b1, 1'b0, "auto2.8");

    // Dwell 0 behaves as 1
    dwell = 8'd0;
    frame_high(4); boundary(2'd2, 1'b1, 1'b0, "auto0.1");
    frame_high(4); boundary(2'd3, 1'b1, 1'b0, "auto0.2");
    auto_en = 1'b0;
    frame_high(4); boundary(2'd3, 1'b0, 1'b0, "auto_off");

    // Host request in the exact fall cycle
    frame_high(4);
    host_req = 1'b1; host_pat = 2'd0; vsync = 1'b0;
    tick();
    check("fallreq.fs",   frame_start, 1);
    check("fallreq.pat",  pattern,     3);
    check("fallreq.chg",  pattern_chg, 0);
    check("fallreq.ack",  host_ack,    1);
    check("fallreq.pend", pending,     1);
    host_pat = 2'd2;
    tick();
    check("second.ack_blocked", host_ack, 0);
    frame_high(5);
    check("second.ack_still_blocked", host_ack, 0);
    vsync = 1'b0;
    tick();
    check("fallreq.b.pat",  pattern,     0);
    check("fallreq.b.chg",  pattern_chg, 1);
    check("fallreq.b.ack",  host_ack,    0);
    check("fallreq.b.pend", pending,     0);
    tick();
    check("second.ack",  host_ack, 1);
    check("second.pend", pending,  1);
    host_req = 1'b0;
    tick();
    check("second.ack_single", host_ack, 0);
    frame_high(4);
    boundary(2'd2, 1'b1, 1'b0, "second.b");

    // Reset mid-frame with requests pending
    auto_en = 1'b1; dwell = 8'd1;
    frame_high(2);
    host_request(2'd3, "mrst.h");
    btn_pulse();
    rst = 1'b1;
    tick();
    check("mrst.pat",  pattern, 1);
    check("mrst.pend", pending, 0);
    check("mrst.ack",  host_ack, 0);
    rst = 1'b0;
    frame_high(4);
    boundary(2'd1, 1'b0, 1'b0, "mrst.lock");
    frame_high(4);
    boundary(2'd2, 1'b1, 1'b0, "mrst.auto");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
